// File: rtl/icache_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_sram_pkg
// Brief    : Shared types and constants for the instruction-cache SRAM
//            controller (fill FSM states, SRAM read latency).
// Revision : 1.0 - initial release
// ============================================================================
package icache_sram_pkg;

    // Cycles from the issuing edge until port-1 read data is usable
    localparam int READ_LAT = 2;

    // Line-fill state machine encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage : icache_sram_pkg
`default_nettype wire

// File: rtl/icache_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : icache_rsp_fifo
// Brief    : Fetch response FIFO. Head is presented combinationally; the
//            producer guarantees it never pushes into a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module icache_rsp_fifo #(
    parameter int WORD_SIZE = 64,
    parameter int RSP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  logic [WORD_SIZE-1:0]           i_push_data,
    input  logic                           i_pop,
    output logic                           o_empty,
    output logic [WORD_SIZE-1:0]           o_head,
    output logic [$clog2(RSP_DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(RSP_DEPTH - 1);

    logic [WORD_SIZE-1:0] r_mem [RSP_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_pop;

    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = i_pop & ~o_empty;

    // Pointer and occupancy bookkeeping; pointers wrap at the depth so
    // non-power-of-two depths work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates validity
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule : icache_rsp_fifo
`default_nettype wire

// File: rtl/icache_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_sram_ctrl
// Brief    : Instruction-cache SRAM controller. Port 0 writes line fills,
//            port 1 serves pipelined fetch reads into a credit-controlled
//            response FIFO. Define ICACHE_SRAM_STATS_EN to add the
//            OUT_stallCycles counter output.
// Revision : 1.0 - initial release
// ============================================================================
module icache_sram_ctrl
    import icache_sram_pkg::*;
#(
    parameter int ADDR_LEN   = 10,
    parameter int WORD_SIZE  = 64,
    parameter int LINE_WORDS = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   IN_fetchValid,
    input  logic [ADDR_LEN-1:0]                    IN_fetchAddr,
    output logic                                   OUT_fetchReady,
    output logic                                   OUT_rspValid,
    output logic [WORD_SIZE-1:0]                   OUT_rspData,
    input  logic                                   IN_rspReady,
    input  logic                                   IN_fillStart,
    input  logic [ADDR_LEN-$clog2(LINE_WORDS)-1:0] IN_fillLine,
    input  logic                                   IN_fillValid,
    input  logic [WORD_SIZE-1:0]                   IN_fillData,
    output logic                                   OUT_fillReady,
    output logic                                   OUT_fillDone,
    output logic                                   OUT_nce0,
    output logic                                   OUT_nwe0,
    output logic [ADDR_LEN-1:0]                    OUT_addr0,
    output logic [WORD_SIZE-1:0]                   OUT_wdata0,
    output logic [WORD_SIZE/8-1:0]                 OUT_wmask0,
    output logic                                   OUT_nce1,
    output logic [ADDR_LEN-1:0]                    OUT_addr1,
    input  logic [WORD_SIZE-1:0]                   IN_rdata1
`ifdef ICACHE_SRAM_STATS_EN
    ,
    output logic [31:0]                            OUT_stallCycles
`endif
);

    localparam int LINE_BITS = $clog2(LINE_WORDS);
    localparam int LINE_W    = ADDR_LEN - LINE_BITS;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int USED_W    = CNT_W + 1;
    localparam logic [LINE_BITS-1:0] C_LAST_WORD = LINE_BITS'(LINE_WORDS - 1);

    fill_state_t          r_state;
    fill_state_t          w_state_nxt;
    logic [LINE_W-1:0]    r_line;
    logic [LINE_W-1:0]    w_line_nxt;
    logic [LINE_BITS-1:0] r_cnt;
    logic [LINE_BITS-1:0] w_cnt_nxt;
    logic [READ_LAT-1:0]  r_vld;
    logic                 r_run;
    logic [CNT_W-1:0]     w_inflight;
    logic [CNT_W-1:0]     w_fifo_cnt;
    logic [USED_W-1:0]    w_used;
    logic                 w_fifo_empty;
    logic                 w_hazard;
    logic                 w_fetch_ready;
    logic                 w_issue;

    // Reads outstanding in the SRAM pipeline
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_vld[i]);
        end
    end

    // Credits use registered occupancy only, so a same-cycle pop never
    // frees a slot early. r_run keeps fetches blocked while in reset.
    assign w_used        = USED_W'(w_inflight) + USED_W'(w_fifo_cnt);
    assign w_hazard      = (r_state == FILL) &&
                           (IN_fetchAddr[ADDR_LEN-1:LINE_BITS] == r_line);
    assign w_fetch_ready = r_run && (w_used < USED_W'(RSP_DEPTH)) && !w_hazard;
    assign w_issue       = IN_fetchValid & w_fetch_ready;

    assign OUT_fetchReady = w_fetch_ready;
    assign OUT_nce1       = ~w_issue;
    assign OUT_addr1      = IN_fetchAddr;
    assign OUT_rspValid   = ~w_fifo_empty;

    // Run flag and read-valid pipeline aligned with SRAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_vld <= '0;
        end else begin
            r_run <= 1'b1;
            r_vld <= {r_vld[READ_LAT-2:0], w_issue};
        end
    end

    icache_rsp_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_vld[READ_LAT-1]),
        .i_push_data (IN_rdata1),
        .i_pop       (IN_rspReady),
        .o_empty     (w_fifo_empty),
        .o_head      (OUT_rspData),
        .o_count     (w_fifo_cnt)
    );

    // Fill FSM state, latched line index and word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign OUT_addr0  = {r_line, r_cnt};
    assign OUT_wdata0 = IN_fillData;
    assign OUT_wmask0 = '1;

    // Fill FSM next state and port-0 write strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_line_nxt    = r_line;
        w_cnt_nxt     = r_cnt;
        OUT_fillReady = 1'b0;
        OUT_fillDone  = 1'b0;
        OUT_nce0      = 1'b1;
        OUT_nwe0      = 1'b1;
        case (r_state)
            IDLE: begin
                if (IN_fillStart) begin
                    w_state_nxt = FILL;
                    w_line_nxt  = IN_fillLine;
                    w_cnt_nxt   = '0;
                end
            end
            FILL: begin
                OUT_fillReady = 1'b1;
                if (IN_fillValid) begin
                    OUT_nce0  = 1'b0;
                    OUT_nwe0  = 1'b0;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == C_LAST_WORD) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                OUT_fillDone = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef ICACHE_SRAM_STATS_EN
    logic [31:0] r_stall;

    // Saturating count of cycles a valid fetch was held off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (IN_fetchValid && !w_fetch_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign OUT_stallCycles = r_stall;
`endif

endmodule : icache_sram_ctrl
`default_nettype wire

// File: tb/tb_icache_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_sram_ctrl
// Brief    : Directed self-checking bench for icache_sram_ctrl with a
//            behavioural two-stage registered-read SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_sram_ctrl;

    localparam int ADDR_LEN   = 10;
    localparam int WORD_SIZE  = 64;
    localparam int LINE_WORDS = 4;
    localparam int RSP_DEPTH  = 4;
    localparam logic [63:0] C_BASE = 64'h1000_0000_0000_0000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  fetch_valid;
    logic [ADDR_LEN-1:0]   fetch_addr;
    logic                  fetch_ready;
    logic                  rsp_valid;
    logic [WORD_SIZE-1:0]  rsp_data;
    logic                  rsp_ready;
    logic                  fill_start;
    logic [ADDR_LEN-3:0]   fill_line;
    logic                  fill_valid;
    logic [WORD_SIZE-1:0]  fill_data;
    logic                  fill_ready;
    logic                  fill_done;
    logic                  nce0;
    logic                  nwe0;
    logic [ADDR_LEN-1:0]   addr0;
    logic [WORD_SIZE-1:0]  wdata0;
    logic [WORD_SIZE/8-1:0] wmask0;
    logic                  nce1;
    logic [ADDR_LEN-1:0]   addr1;
    logic [WORD_SIZE-1:0]  rdata1;
`ifdef ICACHE_SRAM_STATS_EN
    logic [31:0]           stall_cycles;
`endif

    logic [WORD_SIZE-1:0]  mem [1024];
    logic [WORD_SIZE-1:0]  sram_stage;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icache_sram_ctrl #(
        .ADDR_LEN   (ADDR_LEN),
        .WORD_SIZE  (WORD_SIZE),
        .LINE_WORDS (LINE_WORDS),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IN_fetchValid  (fetch_valid),
        .IN_fetchAddr   (fetch_addr),
        .OUT_fetchReady (fetch_ready),
        .OUT_rspValid   (rsp_valid),
        .OUT_rspData    (rsp_data),
        .IN_rspReady    (rsp_ready),
        .IN_fillStart   (fill_start),
        .IN_fillLine    (fill_line),
        .IN_fillValid   (fill_valid),
        .IN_fillData    (fill_data),
        .OUT_fillReady  (fill_ready),
        .OUT_fillDone   (fill_done),
        .OUT_nce0       (nce0),
        .OUT_nwe0       (nwe0),
        .OUT_addr0      (addr0),
        .OUT_wdata0     (wdata0),
        .OUT_wmask0     (wmask0),
        .OUT_nce1       (nce1),
        .OUT_addr1      (addr1),
        .IN_rdata1      (rdata1)
`ifdef ICACHE_SRAM_STATS_EN
        ,
        .OUT_stallCycles (stall_cycles)
`endif
    );

    // SRAM model: port 0 writes, port 1 reads through two registers
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = C_BASE | 64'(i);
        forever begin
            @(posedge clk);
            if (!nce0 && !nwe0) mem[addr0] <= wdata0;
            if (!nce1) sram_stage <= mem[addr1];
            rdata1 <= sram_stage;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        fetch_valid = 1'b1;
        fetch_addr  = 10'h010;
        rsp_ready   = 1'b1;
        fill_start  = 1'b0;
        fill_line   = '0;
        fill_valid  = 1'b0;
        fill_data   = '0;

        // Reset values, with a fetch request pending
        #2;
        chk("rst_rspValid", rsp_valid, 0);
        chk("rst_fillDone", fill_done, 0);
        chk("rst_fillReady", fill_ready, 0);
        chk("rst_nce0", nce0, 1);
        chk("rst_nwe0", nwe0, 1);
        chk("rst_nce1", nce1, 1);
        cyc(); cyc();
        rst_n = 1'b1;
        fetch_valid = 1'b0;
        cyc(); cyc();

        // Single fetch of word 0x010
        fetch_valid = 1'b1; fetch_addr = 10'h010;
        smp();
        chk("f1_ready", fetch_ready, 1);
        chk("f1_nce1", nce1, 0);
        chk("f1_addr1", addr1, 10'h010);
        cyc(); fetch_valid = 1'b0;
        smp(); chk("f1_lat1", rsp_valid, 0);
        cyc();
        smp(); chk("f1_lat2", rsp_valid, 0);
        cyc();
        smp();
        chk("f1_valid", rsp_valid, 1);
        chk("f1_data", rsp_data, 64'h1000_0000_0000_0010);
        cyc();
        smp(); chk("f1_popped", rsp_valid, 0);
        cyc();

        // Back-pressure: only four requests may be accepted
        rsp_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            fetch_valid = 1'b1;
            fetch_addr  = (k < 4) ? 10'(32'h20 + k) : 10'h024;
            smp();
            chk("bp_ready", fetch_ready, (k < 4));
            cyc();
        end
        fetch_valid = 1'b0;
        rsp_ready   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("bp_rspValid", rsp_valid, 1);
            chk("bp_rspData", rsp_data, C_BASE | 64'(32'h20 + k));
            cyc();
        end
        smp(); chk("bp_drained", rsp_valid, 0);
        cyc();

        // Streaming fetches with no bubbles
        for (int k = 0; k < 9; k++) begin
            fetch_valid = (k < 6);
            fetch_addr  = 10'(32'h30 + k);
            smp();
            if (k < 6) chk("st_ready", fetch_ready, 1);
            if (k >= 3) begin
                chk("st_rspValid", rsp_valid, 1);
                chk("st_rspData", rsp_data, C_BASE | 64'(32'h30 + k - 3));
            end else begin
                chk("st_empty", rsp_valid, 0);
            end
            cyc();
        end
        fetch_valid = 1'b0;
        smp(); chk("st_drained", rsp_valid, 0);
        cyc();

        // Fill line 3 with words 0xA..0xD
        fill_start = 1'b1; fill_line = 8'd3;
        smp();
        chk("fl_idle_ready", fill_ready, 0);
        chk("fl_idle_nce0", nce0, 1);
        cyc();
        fill_start = 1'b0; fill_valid = 1'b1; fill_data = 64'hA;
        fetch_valid = 1'b1; fetch_addr = 10'd13;
        smp();
        chk("fl_ready", fill_ready, 1);
        chk("fl_nce0", nce0, 0);
        chk("fl_nwe0", nwe0, 0);
        chk("fl_addr0_w0", addr0, 12);
        chk("fl_wdata0", wdata0, 64'hA);
        chk("fl_wmask0", wmask0, 8'hFF);
        chk("fl_hazard_ready", fetch_ready, 0);
        chk("fl_hazard_nce1", nce1, 1);
        cyc();
        fill_data = 64'hB; fetch_addr = 10'h040;
        smp();
        chk("fl_addr0_w1", addr0, 13);
        chk("fl_other_ready", fetch_ready, 1);
        chk("fl_other_nce1", nce1, 0);
        cyc();
        fetch_valid = 1'b0; fill_data = 64'hC;
        fill_start = 1'b1; fill_line = 8'd7;
        smp();
        chk("fl_addr0_w2", addr0, 14);
        chk("fl_done_early", fill_done, 0);
        cyc();
        fill_start = 1'b0; fill_data = 64'hD;
        smp();
        chk("fl_addr0_w3", addr0, 15);
        cyc();
        fill_valid = 1'b0; fetch_valid = 1'b1; fetch_addr = 10'd13;
        smp();
        chk("fl_done", fill_done, 1);
        chk("fl_done_nce0", nce0, 1);
        chk("fl_done_ready", fetch_ready, 1);
        chk("fl_other_rspValid", rsp_valid, 1);
        chk("fl_other_rspData", rsp_data, C_BASE | 64'h40);
        cyc();
        fetch_valid = 1'b0;
        smp();
        chk("fl_done_pulse", fill_done, 0);
        chk("fl_gap1", rsp_valid, 0);
        cyc();
        smp(); chk("fl_gap2", rsp_valid, 0);
        cyc();
        smp();
        chk("fl_rb_valid", rsp_valid, 1);
        chk("fl_rb_data", rsp_data, 64'hB);
        cyc();

        // Reset with reads in flight and a partial fill
        fill_start = 1'b1; fill_line = 8'd5;
        smp(); cyc();
        fill_start = 1'b0; fill_valid = 1'b1; fill_data = 64'h1;
        fetch_valid = 1'b1; fetch_addr = 10'h050;
        smp(); chk("mr_ready", fetch_ready, 1);
        cyc();
        fill_data = 64'h2; fetch_addr = 10'h051;
        smp(); chk("mr_fill_active", fill_ready, 1);
        cyc();
        fill_data = 64'h3; fetch_addr = 10'h052;
        rst_n = 1'b0;
        #1;
        chk("mr_rspValid", rsp_valid, 0);
        chk("mr_fillReady", fill_ready, 0);
        chk("mr_fillDone", fill_done, 0);
        chk("mr_nce0", nce0, 1);
        chk("mr_nwe0", nwe0, 1);
        chk("mr_nce1", nce1, 1);
        chk("mr_fetchReady", fetch_ready, 0);
        fill_valid = 1'b0; fetch_valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            smp();
            chk("mr_no_rsp", rsp_valid, 0);
            chk("mr_no_done", fill_done, 0);
            cyc();
        end

        // Stalled fetch cycles during a fill of line 0
`ifdef ICACHE_SRAM_STATS_EN
        smp(); chk("sc_reset", stall_cycles, 0);
        cyc();
`endif
        fill_start = 1'b1; fill_line = 8'd0;
        smp(); cyc();
        fill_start = 1'b0; fetch_valid = 1'b1; fetch_addr = 10'h001;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("sc_stalled", fetch_ready, 0);
            cyc();
        end
        fetch_valid = 1'b0;
        smp();
`ifdef ICACHE_SRAM_STATS_EN
        chk("sc_count", stall_cycles, 5);
`endif
        chk("sc_no_rsp", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_icache_sram_ctrl
`default_nettype wire
